filter_scheduler: RTL

Multi-channel glitch-filter controller that shares one stability-count evaluation datapath among NCH input lines. A programmable prescaler issues sample ticks. On each tick an FSM scans every channel in order, updates that channel's stored stability count, and commits a filtered output change once the count reaches a threshold. Each committed change is reported through a valid/ready event port. The block sits between raw pad-level signals and the consuming logic, in place of per-line filter instances.

---
 rtl/filter_scheduler.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/filter_scheduler.sv
// Multi-channel glitch filter: one shared stability-count datapath scans all
// channels on each prescaler tick and reports committed level changes as events.
module filter_scheduler #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 4,
    parameter int PRESC_W = 8,
    parameter int CH_W    = $clog2(NCH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic [CNT_W-1:0]   threshold,
    input  logic [NCH-1:0]     sig_in,
    output logic [NCH-1:0]     sig_out,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [CH_W-1:0]    evt_ch,
    output logic               evt_level,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    logic [NCH-1:0]     sync_meta_r;
    logic [NCH-1:0]     sync_r;
    logic [PRESC_W-1:0] presc_r;
    logic               tick_s;

    state_t             state_r;
    state_t             state_nx_s;
    logic [CH_W-1:0]    idx_r;
    logic [CH_W-1:0]    idx_nx_s;
    logic [CNT_W-1:0]   thr_r;
    logic [CNT_W-1:0]   thr_nx_s;
    logic [CNT_W-1:0]   cnt_r [NCH];

    logic [NCH-1:0]     sig_out_r;
    logic               evt_valid_r;
    logic [CH_W-1:0]    evt_ch_r;
    logic               evt_level_r;
    logic               busy_r;
    logic               overrun_r;

    logic               last_s;
    logic               differ_s;
    logic               reach_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               commit_s;
    logic               clear_s;
    logic               incr_s;

    assign tick_s   = enable & (presc_r == presc_div);
    assign last_s   = (idx_r == CH_W'(NCH - 1));
    assign differ_s = (sync_r[idx_r] != sig_out_r[idx_r]);
    // One extra bit so an all-ones count plus one still compares correctly.
    assign reach_s  = (({1'b0, cnt_r[idx_r]} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, thr_r});
    assign cnt_next_s = (&cnt_r[idx_r]) ? cnt_r[idx_r] : (cnt_r[idx_r] + CNT_W'(1));

    assign sig_out   = sig_out_r;
    assign evt_valid = evt_valid_r;
    assign evt_ch    = evt_ch_r;
    assign evt_level = evt_level_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

    // Two-flop synchronizer for the raw pad inputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta_r <= {NCH{1'b0}};
            sync_r      <= {NCH{1'b0}};
        end else begin
            sync_meta_r <= sig_in;
            sync_r      <= sync_meta_r;
        end
    end

    // Sample-tick prescaler, divider compared live
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_r <= {PRESC_W{1'b0}};
        end else if (!enable) begin
            presc_r <= {PRESC_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PRESC_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    // Sticky flag for ticks that arrive while a scan is still running
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_r <= 1'b0;
        end else if (!enable) begin
            overrun_r <= 1'b0;
        end else if (tick_s && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Scan FSM next-state and per-channel action decode
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        thr_nx_s   = thr_r;
        commit_s   = 1'b0;
        clear_s    = 1'b0;
        incr_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    state_nx_s = ST_SCAN;
                    idx_nx_s   = {CH_W{1'b0}};
                    thr_nx_s   = (threshold == {CNT_W{1'b0}}) ? CNT_W'(1) : threshold;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (differ_s && reach_s) begin
                    commit_s   = 1'b1;
                    state_nx_s = ST_EMIT;
                end else begin
                    clear_s = !differ_s;
                    incr_s  = differ_s;
                    if (last_s) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        idx_nx_s = idx_r + CH_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (evt_ready) begin
                    if (last_s) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_SCAN;
                        idx_nx_s   = idx_r + CH_W'(1);
                    end
                end else begin
                    state_nx_s = ST_EMIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                idx_nx_s   = {CH_W{1'b0}};
            end
        endcase
    end

    // Scan FSM state, channel index, latched threshold and busy flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            idx_r   <= {CH_W{1'b0}};
            thr_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            thr_r   <= thr_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
        end
    end

    // Per-channel stability counters and filtered levels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            sig_out_r <= {NCH{1'b0}};
        end else if (commit_s) begin
            cnt_r[idx_r]     <= {CNT_W{1'b0}};
            sig_out_r[idx_r] <= ~sig_out_r[idx_r];
        end else if (clear_s) begin
            cnt_r[idx_r] <= {CNT_W{1'b0}};
        end else if (incr_s) begin
            cnt_r[idx_r] <= cnt_next_s;
        end else begin
            sig_out_r <= sig_out_r;
        end
    end

    // Event port register; valid drops only on the handshake cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            evt_valid_r <= 1'b0;
            evt_ch_r    <= {CH_W{1'b0}};
            evt_level_r <= 1'b0;
        end else if (commit_s) begin
            evt_valid_r <= 1'b1;
            evt_ch_r    <= idx_r;
            evt_level_r <= sync_r[idx_r];
        end else if ((state_r == ST_EMIT) && evt_ready) begin
            evt_valid_r <= 1'b0;
        end else begin
            evt_valid_r <= evt_valid_r;
        end
    end

endmodule
